ppdu_deframer: RTL and testbench
================================

PPDU_DEFRAMER -- requirements
Module: ppdu_deframer

Interface
REQ-001 SHALL have parameter PRE_MIN, default 32: minimum number of consecutive zero bits that qualify as a preamble (range 8..255).
REQ-002 SHALL have parameter SFD, default 8'hA7: start-of-frame delimiter; SFD[0] must be 1.
REQ-003 SHALL have parameter MAX_LEN, default 127: largest legal PSDU length in bytes.
REQ-004 i_clk  input  1: single clock, rising-edge.
REQ-005 i_rst_n  input  1: reset, asynchronous, active-low.
REQ-006 i_bit_stream  input  1: received bit, sampled only when i_stream_valid=1.
REQ-007 i_stream_valid  input  1: qualifies i_bit_stream for one clock.
REQ-008 o_byte  output  8: assembled PSDU byte.
REQ-009 o_byte_valid  output  1: one-cycle strobe qualifying o_byte.
REQ-010 o_sof  output  1: high together with o_byte_valid on the first PSDU byte.
REQ-011 o_eof  output  1: high together with o_byte_valid on the last PSDU byte.
REQ-012 o_frame_len  output  7: PHR length field, held until the next PHR.
REQ-013 o_len_valid  output  1: one-cycle strobe when o_frame_len updates.
REQ-014 o_sync_err  output  1: one-cycle strobe on SFD mismatch.
REQ-015 o_len_err  output  1: one-cycle strobe on an illegal PHR length.
REQ-016 o_busy  output  1: high in states SFD, PHR and PSDU.

Function
REQ-017 SHALL implement the FSM states HUNT, SFD, PHR and PSDU; only valid bits advance the FSM, and invalid cycles stall it with no state or counter change.
REQ-018 Bit order SHALL be LSB first: the shift register updates as sr <= {bit, sr[7:1]}, and a 3-bit counter counts bits 0..7.
REQ-019 HUNT zero count:
  - a valid 0 increments a zero counter, which saturates at PRE_MIN;
  - a valid 1 with the counter < PRE_MIN clears the counter.
REQ-020 HUNT exit: a valid 1 with the counter = PRE_MIN moves the FSM to SFD, loads that bit as SFD bit 0 and sets the bit count to 1.
REQ-021 SFD state SHALL collect 8 bits in total.
  - On a match with SFD, the FSM goes to PHR.
  - Otherwise it pulses o_sync_err, clears the zero counter and returns to HUNT; there is no overlapping re-search.
REQ-022 PHR state SHALL collect 8 bits; len = PHR[6:0], and PHR[7] (reserved) is ignored.
REQ-023 If 1 <= len <= MAX_LEN:
  - o_frame_len <= len and o_len_valid pulses;
  - a 7-bit remaining-byte counter loads len;
  - the FSM goes to PSDU.
REQ-024 If len = 0 or len > MAX_LEN, the block SHALL pulse o_len_err and return to HUNT with the zero counter cleared; o_frame_len is not updated.
REQ-025 PSDU state: on each 8th bit, the block SHALL register o_byte and pulse o_byte_valid in the next cycle.
  - o_sof is high for the first byte.
  - o_eof is high when the remaining count reaches 1.
  - The remaining count then decrements.
REQ-026 After the eof byte, the FSM SHALL return to HUNT with the zero counter cleared, so a fresh preamble is required.
REQ-027 A single-byte frame (len = 1) SHALL assert o_sof and o_eof in the same cycle.
REQ-028 Output latency SHALL be exactly one clock from the valid bit that completes a byte or field to the corresponding strobe.
REQ-029 All outputs SHALL be registered, and every strobe SHALL be high for exactly one cycle.
REQ-030 Back-to-back valid bits on every clock SHALL be supported without loss.

Reset
REQ-031 Asserting i_rst_n=0 at any time, including mid-frame, SHALL immediately force:
  - state to HUNT;
  - all counters and the shift register to 0;
  - o_byte=0, o_frame_len=0, and every strobe and o_busy to 0.
REQ-032 After reset release, the first valid bit SHALL be processed in HUNT, and no partial frame SHALL be resumed.

Verification
REQ-033 32 zeros, SFD 0xA7, PHR 0x03, bytes 0x11 0x22 0x33, one bit per clock:
  - o_len_valid with o_frame_len=3;
  - three o_byte_valid strobes carrying 0x11, 0x22, 0x33;
  - o_sof on 0x11 and o_eof on 0x33, each one clock after its last bit;
  - o_busy then returns to 0.
REQ-034 The same frame with i_stream_valid toggling 1/0 every cycle -> identical bytes and flags, with no extra strobes.
REQ-035 31 zeros then SFD -> no frame. 40 zeros, SFD 0xA6, then a valid frame:
  - o_sync_err pulses once;
  - the first frame is dropped;
  - the second frame is received correctly.
REQ-036 PHR 0x00, then a separate frame with PHR 0x80 (len 0) -> o_len_err pulses each time, with no o_byte_valid and o_frame_len unchanged.
REQ-037 PHR 0x01 with byte 0xA5 -> a single strobe with o_sof=o_eof=1 and o_byte=0xA5.
REQ-038 Reset asserted after the 2nd PSDU byte of a 5-byte frame:
  - outputs clear immediately;
  - after release, the rest of the old frame produces no output;
  - a new full frame is received correctly.

Source files
------------

// File: rtl/ppdu_deframer.sv
// Bit-serial PPDU deframer: preamble hunt, SFD match, PHR length decode and
// LSB-first PSDU byte assembly with registered one-cycle strobes.
module ppdu_deframer #(
    parameter int unsigned PRE_MIN = 32,
    parameter logic [7:0]  SFD     = 8'hA7,
    parameter int unsigned MAX_LEN = 127
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_bit_stream,
    input  logic       i_stream_valid,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_sof,
    output logic       o_eof,
    output logic [6:0] o_frame_len,
    output logic       o_len_valid,
    output logic       o_sync_err,
    output logic       o_len_err,
    output logic       o_busy
);

    typedef enum logic [1:0] {ST_HUNT, ST_SFD, ST_PHR, ST_PSDU} state_e;

    localparam logic [7:0] PreMin = 8'(PRE_MIN);

    state_e     state_q, state_d;
    logic [7:0] zcnt_q, zcnt_d;
    logic [7:0] sr_q, sr_d;
    logic [2:0] bcnt_q, bcnt_d;
    logic [6:0] rem_q, rem_d;
    logic       first_q, first_d;
    logic [7:0] byte_q, byte_d;
    logic       byte_valid_q, byte_valid_d;
    logic       sof_q, sof_d;
    logic       eof_q, eof_d;
    logic [6:0] frame_len_q, frame_len_d;
    logic       len_valid_q, len_valid_d;
    logic       sync_err_q, sync_err_d;
    logic       len_err_q, len_err_d;
    logic       busy_q, busy_d;

    logic [7:0] sr_shift;
    logic [6:0] phr_len;

    assign sr_shift = {i_bit_stream, sr_q[7:1]};
    assign phr_len  = sr_shift[6:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_HUNT;
            zcnt_q       <= '0;
            sr_q         <= '0;
            bcnt_q       <= '0;
            rem_q        <= '0;
            first_q      <= 1'b0;
            byte_q       <= '0;
            byte_valid_q <= 1'b0;
            sof_q        <= 1'b0;
            eof_q        <= 1'b0;
            frame_len_q  <= '0;
            len_valid_q  <= 1'b0;
            sync_err_q   <= 1'b0;
            len_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            zcnt_q       <= zcnt_d;
            sr_q         <= sr_d;
            bcnt_q       <= bcnt_d;
            rem_q        <= rem_d;
            first_q      <= first_d;
            byte_q       <= byte_d;
            byte_valid_q <= byte_valid_d;
            sof_q        <= sof_d;
            eof_q        <= eof_d;
            frame_len_q  <= frame_len_d;
            len_valid_q  <= len_valid_d;
            sync_err_q   <= sync_err_d;
            len_err_q    <= len_err_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        zcnt_d       = zcnt_q;
        sr_d         = sr_q;
        bcnt_d       = bcnt_q;
        rem_d        = rem_q;
        first_d      = first_q;
        byte_d       = byte_q;
        frame_len_d  = frame_len_q;
        byte_valid_d = 1'b0;
        sof_d        = 1'b0;
        eof_d        = 1'b0;
        len_valid_d  = 1'b0;
        sync_err_d   = 1'b0;
        len_err_d    = 1'b0;

        if (i_stream_valid) begin
            unique case (state_q)
                ST_HUNT: begin
                    if (!i_bit_stream) begin
                        if (zcnt_q != PreMin) zcnt_d = zcnt_q + 8'd1;
                    end else if (zcnt_q == PreMin) begin
                        // The qualifying 1 is already SFD bit 0.
                        state_d = ST_SFD;
                        sr_d    = sr_shift;
                        bcnt_d  = 3'd1;
                    end else begin
                        zcnt_d = '0;
                    end
                end
                ST_SFD: begin
                    sr_d   = sr_shift;
                    bcnt_d = bcnt_q + 3'd1;
                    if (bcnt_q == 3'd7) begin
                        if (sr_shift == SFD) begin
                            state_d = ST_PHR;
                        end else begin
                            state_d    = ST_HUNT;
                            sync_err_d = 1'b1;
                            zcnt_d     = '0;
                        end
                    end
                end
                ST_PHR: begin
                    sr_d   = sr_shift;
                    bcnt_d = bcnt_q + 3'd1;
                    if (bcnt_q == 3'd7) begin
                        if ((phr_len != 7'd0) && (32'(phr_len) <= MAX_LEN)) begin
                            state_d     = ST_PSDU;
                            frame_len_d = phr_len;
                            len_valid_d = 1'b1;
                            rem_d       = phr_len;
                            first_d     = 1'b1;
                        end else begin
                            state_d   = ST_HUNT;
                            len_err_d = 1'b1;
                            zcnt_d    = '0;
                        end
                    end
                end
                ST_PSDU: begin
                    sr_d   = sr_shift;
                    bcnt_d = bcnt_q + 3'd1;
                    if (bcnt_q == 3'd7) begin
                        byte_d       = sr_shift;
                        byte_valid_d = 1'b1;
                        sof_d        = first_q;
                        first_d      = 1'b0;
                        eof_d        = (rem_q == 7'd1);
                        rem_d        = rem_q - 7'd1;
                        if (rem_q == 7'd1) begin
                            state_d = ST_HUNT;
                            zcnt_d  = '0;
                        end
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end

        busy_d = (state_d != ST_HUNT);
    end

    assign o_byte       = byte_q;
    assign o_byte_valid = byte_valid_q;
    assign o_sof        = sof_q;
    assign o_eof        = eof_q;
    assign o_frame_len  = frame_len_q;
    assign o_len_valid  = len_valid_q;
    assign o_sync_err   = sync_err_q;
    assign o_len_err    = len_err_q;
    assign o_busy       = busy_q;

endmodule

// File: tb/tb_ppdu_deframer.sv
// Directed bench for ppdu_deframer: framing, stalls, sync/length errors,
// single-byte frames and mid-frame reset, checked with immediate assertions.
module tb_ppdu_deframer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bit_in = 1'b0;
    logic       vld = 1'b0;
    logic [7:0] o_byte;
    logic       o_byte_valid, o_sof, o_eof, o_len_valid, o_sync_err, o_len_err, o_busy;
    logic [6:0] o_frame_len;

    int total = 0;
    int bad   = 0;

    logic [9:0] cap[$];
    int n_sync = 0;
    int n_lerr = 0;
    int n_lval = 0;

    ppdu_deframer #(.PRE_MIN(32), .SFD(8'hA7), .MAX_LEN(127)) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_bit_stream(bit_in),
        .i_stream_valid(vld),
        .o_byte(o_byte),
        .o_byte_valid(o_byte_valid),
        .o_sof(o_sof),
        .o_eof(o_eof),
        .o_frame_len(o_frame_len),
        .o_len_valid(o_len_valid),
        .o_sync_err(o_sync_err),
        .o_len_err(o_len_err),
        .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, sample 1 time unit after the rising edge.
    task automatic tick(input logic v, input logic b);
        @(negedge clk);
        vld    = v;
        bit_in = b;
        @(posedge clk);
        #1;
        if (o_byte_valid) cap.push_back({o_sof, o_eof, o_byte});
        if (o_sync_err) n_sync++;
        if (o_len_err) n_lerr++;
        if (o_len_valid) n_lval++;
    endtask

    task automatic clear_logs();
        cap.delete();
        n_sync = 0;
        n_lerr = 0;
        n_lval = 0;
    endtask

    task automatic send_zeros(input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            if (gap) tick(1'b0, 1'b1);
            tick(1'b1, 1'b0);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input bit gap);
        for (int i = 0; i < 8; i++) begin
            if (gap) tick(1'b0, ~d[i]);
            tick(1'b1, d[i]);
        end
    endtask

    task automatic send_frame(input int nz, input logic [7:0] sfd, input logic [7:0] phr,
                              input logic [63:0] pl, input int n, input bit gap);
        send_zeros(nz, gap);
        send_byte(sfd, gap);
        send_byte(phr, gap);
        for (int i = 0; i < n; i++) send_byte(pl[8*i +: 8], gap);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_byte", 32'(o_byte), 32'h00);
        chk("rst_byte_valid", 32'(o_byte_valid), 32'd0);
        chk("rst_frame_len", 32'(o_frame_len), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic frame, one bit per clock, with per-byte latency checks
        clear_logs();
        send_zeros(32, 1'b0);
        chk("a_busy_hunt", 32'(o_busy), 32'd0);
        send_byte(8'hA7, 1'b0);
        chk("a_busy_sfd", 32'(o_busy), 32'd1);
        send_byte(8'h03, 1'b0);
        chk("a_len_valid", 32'(o_len_valid), 32'd1);
        chk("a_frame_len", 32'(o_frame_len), 32'd3);
        send_byte(8'h11, 1'b0);
        chk("a_b0", {22'd0, o_byte_valid, o_sof, o_eof, o_byte}, {22'd0, 3'b110, 8'h11});
        send_byte(8'h22, 1'b0);
        chk("a_b1", {22'd0, o_byte_valid, o_sof, o_eof, o_byte}, {22'd0, 3'b100, 8'h22});
        send_byte(8'h33, 1'b0);
        chk("a_b2", {22'd0, o_byte_valid, o_sof, o_eof, o_byte}, {22'd0, 3'b101, 8'h33});
        chk("a_busy_end", 32'(o_busy), 32'd0);
        tick(1'b0, 1'b0);
        chk("a_strobe_drop", 32'(o_byte_valid), 32'd0);
        chk("a_nbytes", 32'(cap.size()), 32'd3);
        chk("a_nlval", 32'(n_lval), 32'd1);

        // Same frame with valid toggling every cycle
        clear_logs();
        send_frame(32, 8'hA7, 8'h03, 64'h33_22_11, 3, 1'b1);
        tick(1'b0, 1'b0);
        chk("b_nbytes", 32'(cap.size()), 32'd3);
        if (cap.size() == 3) begin
            chk("b_b0", 32'(cap[0]), {22'd0, 2'b10, 8'h11});
            chk("b_b1", 32'(cap[1]), {22'd0, 2'b00, 8'h22});
            chk("b_b2", 32'(cap[2]), {22'd0, 2'b01, 8'h33});
        end
        chk("b_nlval", 32'(n_lval), 32'd1);
        chk("b_frame_len", 32'(o_frame_len), 32'd3);

        // Short preamble: no frame
        clear_logs();
        send_frame(31, 8'hA7, 8'h03, 64'h33_22_11, 3, 1'b0);
        chk("c_nbytes", 32'(cap.size()), 32'd0);
        chk("c_nlval", 32'(n_lval), 32'd0);
        chk("c_nsync", 32'(n_sync), 32'd0);

        // Bad SFD drops the frame, following good frame is received
        clear_logs();
        send_frame(40, 8'hA6, 8'h03, 64'h77_66_55, 3, 1'b0);
        send_frame(32, 8'hA7, 8'h02, 64'hBB_AA, 2, 1'b0);
        chk("d_nsync", 32'(n_sync), 32'd1);
        chk("d_nbytes", 32'(cap.size()), 32'd2);
        if (cap.size() == 2) begin
            chk("d_b0", 32'(cap[0]), {22'd0, 2'b10, 8'hAA});
            chk("d_b1", 32'(cap[1]), {22'd0, 2'b01, 8'hBB});
        end
        chk("d_frame_len", 32'(o_frame_len), 32'd2);
        chk("d_nlval", 32'(n_lval), 32'd1);

        // Zero length PHR, with and without reserved bit
        clear_logs();
        send_frame(32, 8'hA7, 8'h00, 64'h0, 0, 1'b0);
        chk("e_len_err_now", 32'(o_len_err), 32'd1);
        chk("e_nlerr1", 32'(n_lerr), 32'd1);
        send_frame(32, 8'hA7, 8'h80, 64'h0, 0, 1'b0);
        tick(1'b0, 1'b0);
        chk("e_nlerr2", 32'(n_lerr), 32'd2);
        chk("e_nbytes", 32'(cap.size()), 32'd0);
        chk("e_nlval", 32'(n_lval), 32'd0);
        chk("e_frame_len", 32'(o_frame_len), 32'd2);

        // Single byte frame
        clear_logs();
        send_frame(32, 8'hA7, 8'h01, 64'hA5, 1, 1'b0);
        chk("f_byte", {22'd0, o_byte_valid, o_sof, o_eof, o_byte}, {22'd0, 3'b111, 8'hA5});
        tick(1'b0, 1'b0);
        chk("f_nbytes", 32'(cap.size()), 32'd1);
        chk("f_frame_len", 32'(o_frame_len), 32'd1);

        // Reset after second byte of a five byte frame
        clear_logs();
        send_frame(32, 8'hA7, 8'h05, 64'hC2_C1, 2, 1'b0);
        chk("g_pre_byte", {22'd0, o_byte_valid, o_sof, o_eof, o_byte}, {22'd0, 3'b100, 8'hC2});
        #2;
        rst_n = 1'b0;
        #1;
        chk("g_rst_byte", 32'(o_byte), 32'h00);
        chk("g_rst_bv", 32'(o_byte_valid), 32'd0);
        chk("g_rst_len", 32'(o_frame_len), 32'd0);
        chk("g_rst_busy", 32'(o_busy), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
        send_byte(8'hC3, 1'b0);
        send_byte(8'hC4, 1'b0);
        send_byte(8'hC5, 1'b0);
        chk("g_tail_nbytes", 32'(cap.size()), 32'd0);
        chk("g_tail_busy", 32'(o_busy), 32'd0);
        send_frame(32, 8'hA7, 8'h02, 64'hE2_E1, 2, 1'b0);
        chk("g_nbytes", 32'(cap.size()), 32'd2);
        if (cap.size() == 2) begin
            chk("g_b0", 32'(cap[0]), {22'd0, 2'b10, 8'hE1});
            chk("g_b1", 32'(cap[1]), {22'd0, 2'b01, 8'hE2});
        end
        chk("g_frame_len", 32'(o_frame_len), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
